// File: rtl/cpu_pkg.sv
// Purpose: shared types and constants for the multicycle 8-bit CPU and its memory responder.
// Latency: none; declarations only.
// Backpressure: not applicable.
// Contents: bus widths, responder FSM state encoding and arbiter grant encoding.
package cpu_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } grant_t;

endpackage

// File: rtl/mem_responder_if.sv
// Purpose: req/ack bus between the CPU (fetch + data ports) and the memory responder.
// Latency: none; wires only.
// Backpressure: each req is held by its initiator until the matching one-cycle ack.
// Modports: master = CPU side (drives requests), slave = responder side (drives acks/rdata/busy).
interface mem_responder_if;
  import cpu_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  logic              busy;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, busy
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, busy
  );

endinterface

// File: rtl/mem_array_sp.sv
// Purpose: synchronous single-port RAM, one access per cycle when en is high.
// Latency: read data registered, valid the cycle after the enabled read edge.
// Backpressure: none; the caller owns scheduling. Ports: clk, en, we, addr, wdata, rdata.
// Contents are not reset; rdata holds its last read value when not reading.
module mem_array_sp #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Purpose: round-robin responder serving the CPU fetch and data ports from one single-port RAM.
// Latency: ack WAIT_CYCLES+1 cycles after the IDLE cycle that samples req; acks spaced >= WAIT_CYCLES+2.
// Backpressure: requesters hold req until ack; one transaction in flight, the other port waits in IDLE.
// Ports: clk, rst (sync, active-high), bus (slave modport: fetch req/addr/ack/rdata, data req/we/addr/wdata/ack/rdata, busy).
module mem_responder
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  grant_t            last_grant, cur_port, winner;
  logic [AW-1:0]     lat_addr;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        wait_cnt;
  logic [DATA_W-1:0] if_rdata_q, dm_rdata_q;

  logic              any_req;
  logic [AW-1:0]     sel_addr;
  logic              sel_we;
  logic              ram_access;
  logic              ram_en, ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  // Arbiter: a lone request wins; on contention the port that did not win last time goes.
  always_comb begin
    any_req = bus.if_req | bus.dm_req;
    if (bus.if_req && bus.dm_req) begin
      winner = (last_grant == FETCH) ? DATA : FETCH;
    end else if (bus.dm_req) begin
      winner = DATA;
    end else begin
      winner = FETCH;
    end
    // Upper address bits fall away here, so addresses wrap modulo DEPTH.
    sel_addr = (winner == DATA) ? bus.dm_addr[AW-1:0] : bus.if_addr[AW-1:0];
    sel_we   = (winner == DATA) && bus.dm_we;
  end

  // Next state, plus the RAM access that must land on the edge entering RESP.
  always_comb begin
    state_nxt  = state;
    ram_access = 1'b0;
    ram_addr   = lat_addr;
    ram_we     = lat_we;
    ram_wdata  = lat_wdata;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
          end else begin
            // Zero wait states: nothing is latched yet, so access with the live winner.
            state_nxt  = RESP;
            ram_access = 1'b1;
            ram_addr   = sel_addr;
            ram_we     = sel_we;
            ram_wdata  = bus.dm_wdata;
          end
        end
      end
      WAIT: begin
        if (wait_cnt == 4'd0) begin
          state_nxt  = RESP;
          ram_access = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset on the commit edge drops the access, so an in-flight write never lands.
  assign ram_en = ram_access && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= FETCH;
      cur_port   <= FETCH;
      lat_addr   <= '0;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      wait_cnt   <= 4'd0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && any_req) begin
        cur_port   <= winner;
        last_grant <= winner;
        lat_addr   <= sel_addr;
        lat_we     <= sel_we;
        lat_wdata  <= bus.dm_wdata;
        wait_cnt   <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      // Capture the read result at the end of RESP so each port's rdata holds afterwards.
      if (state == RESP) begin
        if (cur_port == FETCH) begin
          if_rdata_q <= ram_rdata;
        end else if (!lat_we) begin
          dm_rdata_q <= ram_rdata;
        end
      end
    end
  end

  mem_array_sp #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // Only one port can be granted, so the acks are mutually exclusive by construction.
  assign bus.if_ack   = (state == RESP) && (cur_port == FETCH) && !rst;
  assign bus.dm_ack   = (state == RESP) && (cur_port == DATA) && !rst;
  assign bus.if_rdata = bus.if_ack ? ram_rdata : if_rdata_q;
  assign bus.dm_rdata = (bus.dm_ack && !lat_we) ? ram_rdata : dm_rdata_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Purpose: self-checking bench for mem_responder (WAIT_CYCLES=2/DEPTH=256 and WAIT_CYCLES=0/DEPTH=16).
// Latency: n/a.
// Backpressure: n/a; requests are held until ack and dropped right after.
module tb_mem_responder;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;

  mem_responder_if b0 ();
  mem_responder_if b1 ();

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u0 (.clk(clk), .rst(rst0), .bus(b0));
  mem_responder #(.DEPTH(16),  .WAIT_CYCLES(0)) u1 (.clk(clk), .rst(rst1), .bus(b1));

  typedef struct {
    bit         dm;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;  // rdata of the acked port during its ack
    logic [7:0] exp_other;  // rdata of the other port, which must be untouched
  } vec_t;

  typedef struct {
    bit         dm;
    logic [7:0] rdata;
  } sb_t;

  vec_t vecs[8];
  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset0();
    rst0 = 1'b1;
    tick();
    tick();
    rst0 = 1'b0;
  endtask

  // Scoreboard: every ack of the WAIT_CYCLES=2 instance must match the oldest pushed expectation.
  always @(negedge clk) begin
    sb_t e;
    if (b0.if_ack && b0.dm_ack) begin
      check("ack_overlap", 32'd1, 32'd0);
    end else if (b0.if_ack || b0.dm_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", {b0.if_ack, b0.dm_ack}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_port", b0.dm_ack, e.dm);
        check("ack_rdata", b0.dm_ack ? b0.dm_rdata : b0.if_rdata, e.rdata);
      end
    end
  end

  task automatic do_xact(input vec_t v);
    int  lat;
    bit  got;
    sb_t e;
    e.dm = v.dm;
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    if (v.dm) begin
      b0.dm_req = 1'b1; b0.dm_we = v.we; b0.dm_addr = v.addr; b0.dm_wdata = v.wdata;
    end else begin
      b0.if_req = 1'b1; b0.if_addr = v.addr;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (lat == 1) begin
        check("busy_in_flight", b0.busy, 1'b1);
        // Values were latched in IDLE; scrambling them now must have no effect.
        b0.dm_addr = ~v.addr; b0.dm_wdata = ~v.wdata; b0.if_addr = ~v.addr;
      end
      got = v.dm ? b0.dm_ack : b0.if_ack;
    end
    check("ack_latency", lat, 32'd3);
    check("other_rdata", v.dm ? b0.if_rdata : b0.dm_rdata, v.exp_other);
    b0.if_req = 1'b0; b0.dm_req = 1'b0; b0.dm_we = 1'b0;
    tick();
    check("idle_after_ack", {b0.busy, b0.if_ack, b0.dm_ack}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    int  dm_at, if_at;
    sb_t e;
    vec_t rd;

    b0.if_req = 0; b0.if_addr = 0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = 0; b0.dm_wdata = 0;
    b1.if_req = 0; b1.if_addr = 0; b1.dm_req = 0; b1.dm_we = 0; b1.dm_addr = 0; b1.dm_wdata = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;

    //            dm  we  addr   wdata  exp_rd exp_other
    vecs[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'h20, 8'h11, 8'hA5, 8'hA5};
    vecs[4] = '{1'b1, 1'b1, 8'h3F, 8'hC3, 8'hA5, 8'hA5};
    vecs[5] = '{1'b0, 1'b0, 8'h3F, 8'h00, 8'hC3, 8'hA5};
    vecs[6] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 8'hC3};
    vecs[7] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h11, 8'h11};

    tick();
    tick();
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Reset state held for 10 idle cycles.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("reset_state", {b0.if_ack, b0.dm_ack, b0.if_rdata, b0.dm_rdata, b0.busy}, 32'd0);
    end

    for (int i = 0; i < 8; i++) do_xact(vecs[i]);

    // Contention twice after reset: data wins first, and again once last_grant is FETCH.
    reset0();
    for (int r = 0; r < 2; r++) begin
      e.dm = 1'b1; e.rdata = 8'hC3; sb_q.push_back(e);
      e.dm = 1'b0; e.rdata = 8'hA5; sb_q.push_back(e);
      b0.dm_req = 1'b1; b0.dm_we = 1'b0; b0.dm_addr = 8'h3F;
      b0.if_req = 1'b1; b0.if_addr = 8'h10;
      dm_at = -1;
      if_at = -1;
      for (int c = 1; c <= 20 && if_at < 0; c++) begin
        tick();
        if (b0.dm_ack) begin dm_at = c; b0.dm_req = 1'b0; end
        if (b0.if_ack) begin if_at = c; b0.if_req = 1'b0; end
      end
      check("contention_dm_ack_cycle", dm_at, 32'd3);
      check("contention_if_ack_cycle", if_at, 32'd7);
      tick();
    end

    // Reset during WAIT of a write: no ack, and the old word survives.
    b0.dm_req = 1'b1; b0.dm_we = 1'b1; b0.dm_addr = 8'h20; b0.dm_wdata = 8'h99;
    tick();
    check("busy_before_reset", b0.busy, 1'b1);
    rst0 = 1'b1;
    b0.dm_req = 1'b0; b0.dm_we = 1'b0;
    tick();
    rst0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("no_ack_after_reset", {b0.busy, b0.if_ack, b0.dm_ack}, 32'd0);
      tick();
    end
    rd = '{1'b1, 1'b0, 8'h20, 8'h00, 8'h11, 8'h00};
    do_xact(rd);

    // Zero wait states on a 16-word array.
    b1.dm_req = 1'b1; b1.dm_we = 1'b1; b1.dm_addr = 8'h03; b1.dm_wdata = 8'h5A;
    tick();
    check("w0_write_ack", b1.dm_ack, 1'b1);
    b1.dm_req = 1'b0; b1.dm_we = 1'b0;
    tick();
    check("w0_idle", {b1.busy, b1.dm_ack}, 32'd0);
    b1.if_req = 1'b1; b1.if_addr = 8'h13;
    for (int t = 1; t <= 12; t++) begin
      tick();
      check("w0_if_ack_pattern", b1.if_ack, t % 2);
      if (t % 2 == 1) check("w0_alias_fetch", b1.if_rdata, 8'h5A);
    end
    b1.if_req = 1'b0;
    tick();
    b1.dm_req = 1'b1; b1.dm_we = 1'b0; b1.dm_addr = 8'h13;
    tick();
    check("w0_read_ack", b1.dm_ack, 1'b1);
    check("w0_alias_read", b1.dm_rdata, 8'h5A);
    b1.dm_req = 1'b0;
    tick();
    check("w0_rdata_hold", b1.dm_rdata, 8'h5A);

    tick();
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
